rr_mux_sel_arbiter: RTL and testbench
=====================================

// Module: rr_mux_sel_arbiter
// PURPOSE
//  Round-robin arbiter that generates the select for the 2:1 data mux and registers the mux result.
//  Sits directly upstream of the mux select and downstream of two valid/ready producers.
//  Picks one pending source per cycle, drives sel, and captures the muxed word into an output register.
//  The output register has a valid/ready handshake toward the consumer.
// PARAMETERS
//  DATA_W     8    width of din_0, din_1, mux_out
//  LAST_INIT  1    reset value of last_sel; 1 => din_0 wins the first contention
// PORTS
//  clk            input   1       rising-edge clock
//  reset          input   1       synchronous, active-high reset
//  din_0          input   DATA_W  source 0 data
//  din_0_valid    input   1       source 0 has data
//  din_0_ready    output  1       source 0 word accepted this cycle (valid & ready)
//  din_1          input   DATA_W  source 1 data
//  din_1_valid    input   1       source 1 has data
//  din_1_ready    output  1       source 1 word accepted this cycle
//  sel            output  1       combinational mux select for this cycle (0=din_0, 1=din_1)
//  mux_out        output  DATA_W  registered muxed data
//  mux_out_valid  output  1       mux_out holds an unconsumed word
//  mux_out_ready  input   1       consumer accepts mux_out this cycle
// BEHAVIOUR
//  Clock and reset: single clock domain; reset is synchronous and active-high.
//  Reset values: mux_out=0, mux_out_valid=0, last_sel=LAST_INIT, state=EMPTY.
//  State machine: state=EMPTY when out_valid=0; state=FULL when out_valid=1.
//  Load condition: load = (state==EMPTY) | mux_out_ready. A stalled FULL register blocks new loads.
//  Winner selection:
//   - only din_0_valid set -> winner 0
//   - only din_1_valid set -> winner 1
//   - both set -> winner = ~last_sel
//   - neither set -> no winner; sel holds last_sel
//  Handshake outputs:
//   - sel = winner when one exists, otherwise sel = last_sel
//   - din_0_ready = load & winner==0 & din_0_valid
//   - din_1_ready = load & winner==1 & din_1_valid
//   - the loser's ready is 0 in the same cycle
//  Acceptance (load & winner exists), at the next edge:
//   - mux_out <= sel ? din_1 : din_0
//   - mux_out_valid <= 1
//   - last_sel <= winner
//  Drain: load with no winner clears mux_out_valid; mux_out keeps its old value.
//  Stall: FULL & ~mux_out_ready holds mux_out, mux_out_valid and last_sel; all readys are 0.
//  Latency and rate: 1 cycle from input accept to mux_out_valid. Sustained rate is 1 word/cycle.
//  Simultaneous events: when mux_out_ready and a new accept occur together, the old word leaves
//   and the new word loads in the same edge, with no bubble.
//  Fairness: with both sources valid continuously and the consumer always ready, grants alternate
//   0,1,0,1... (first grant is ~LAST_INIT).
//  Reset mid-operation: any pending word is dropped and readys deassert in the reset cycle.
//   Arbitration restarts from LAST_INIT.
//  Input contract: valid is not required to stay high when ready=0. The arbiter treats each cycle
//   independently, so sources may withdraw a request.
// CONFIGURATION
//  ARB_STATS_EN defined:
//   - adds outputs gnt_cnt_0 and gnt_cnt_1 (16 bits each)
//   - adds input stats_clr
//   - a counter increments on each accept of its source and wraps 16'hFFFF -> 0
//   - reset or stats_clr clears both counters
//   - stats_clr has priority over an increment in the same cycle
//  ARB_STATS_EN undefined: none of these ports or registers exist; datapath behaviour is identical.
// TESTING
//  1. Reset asserted 2 cycles with both valid -> readys=0, mux_out_valid=0, mux_out=0 throughout.
//  2. din_0=8'hA5 valid alone, consumer ready -> din_0_ready=1, sel=0; next cycle mux_out=A5, valid=1.
//  3. Both valid continuously (din_0=11, din_1=22), consumer ready, LAST_INIT=1
//     -> mux_out sequence 11,22,11,22; exactly one ready per cycle.
//  4. FULL with mux_out_ready=0 for 3 cycles, both valid -> mux_out stable, readys 0.
//     On the ready cycle the next word loads with no bubble.
//  5. Reset asserted while FULL holding 8'h3C -> next cycle mux_out_valid=0.
//     First post-reset contention is granted to din_0.
//  6. ARB_STATS_EN: 5 grants to src0, 3 to src1 -> gnt_cnt_0=5, gnt_cnt_1=3.
//     stats_clr in the same cycle as a grant -> 0. Preload 16'hFFFF + 1 grant -> 0.

Source files
------------

// File: rtl/rr_mux_sel_arbiter.sv
// rr_mux_sel_arbiter
//  Two-source round-robin arbiter driving a 2:1 mux select, with a registered,
//  valid/ready-handshaked output word.
//  Optional feature macro: ARB_STATS_EN adds per-source 16-bit grant counters
//  (gnt_cnt_0, gnt_cnt_1) and a stats_clr input.
module rr_mux_sel_arbiter #(
    parameter int   DATA_W    = 8,
    parameter logic LAST_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din_0,
    input  logic              din_0_valid,
    output logic              din_0_ready,
    input  logic [DATA_W-1:0] din_1,
    input  logic              din_1_valid,
    output logic              din_1_ready,
    output logic              sel,
    output logic [DATA_W-1:0] mux_out,
    output logic              mux_out_valid,
    input  logic              mux_out_ready
`ifdef ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       gnt_cnt_0,
    output logic [15:0]       gnt_cnt_1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              last_sel_reg;
    logic [DATA_W-1:0] mux_out_reg;

    logic              load;
    logic              has_winner;
    logic              winner;
    logic              accept;

    // Arbitration, load decision and next state for this cycle
    always_comb begin
        load       = (state_reg == EMPTY) | mux_out_ready;
        has_winner = din_0_valid | din_1_valid;
        winner     = last_sel_reg;
        if (din_0_valid && din_1_valid) begin
            winner = ~last_sel_reg;
        end else if (din_0_valid) begin
            winner = 1'b0;
        end else if (din_1_valid) begin
            winner = 1'b1;
        end
        // Readys are forced low while reset is asserted so nothing is
        // reported as accepted in a cycle whose word will be dropped.
        accept     = load & has_winner & ~reset;
        state_next = state_reg;
        if (load) begin
            state_next = has_winner ? FULL : EMPTY;
        end
    end

    assign sel           = winner;
    assign din_0_ready   = accept & ~winner;
    assign din_1_ready   = accept & winner;
    assign mux_out       = mux_out_reg;
    assign mux_out_valid = (state_reg == FULL);

    // State, output word and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            mux_out_reg  <= '0;
            last_sel_reg <= LAST_INIT;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                mux_out_reg  <= winner ? din_1 : din_0;
                last_sel_reg <= winner;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [1:0]  grant;
    logic [15:0] gnt_cnt_w [2];

    assign grant = {din_1_ready, din_0_ready};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [15:0] cnt_reg;

        // Per-source grant counter; clear wins over a same-cycle grant, wraps naturally
        always_ff @(posedge clk) begin
            if (reset || stats_clr) begin
                cnt_reg <= '0;
            end else if (grant[gi]) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end

        assign gnt_cnt_w[gi] = cnt_reg;
    end

    assign gnt_cnt_0 = gnt_cnt_w[0];
    assign gnt_cnt_1 = gnt_cnt_w[1];
`endif

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// tb_rr_mux_sel_arbiter
//  Directed bench for rr_mux_sel_arbiter (DATA_W=8, LAST_INIT=1).
//  Stats checks are included when ARB_STATS_EN is defined.
module tb_rr_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_0;
    logic       din_0_valid;
    logic       din_0_ready;
    logic [7:0] din_1;
    logic       din_1_valid;
    logic       din_1_ready;
    logic       sel;
    logic [7:0] mux_out;
    logic       mux_out_valid;
    logic       mux_out_ready;
`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] gnt_cnt_0;
    logic [15:0] gnt_cnt_1;
`endif

    int vectors = 0;
    int errors  = 0;

    rr_mux_sel_arbiter #(
        .DATA_W    (8),
        .LAST_INIT (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .din_0         (din_0),
        .din_0_valid   (din_0_valid),
        .din_0_ready   (din_0_ready),
        .din_1         (din_1),
        .din_1_valid   (din_1_valid),
        .din_1_ready   (din_1_ready),
        .sel           (sel),
        .mux_out       (mux_out),
        .mux_out_valid (mux_out_valid),
        .mux_out_ready (mux_out_ready)
`ifdef ARB_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .gnt_cnt_0     (gnt_cnt_0),
        .gnt_cnt_1     (gnt_cnt_1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1, input logic rdy);
        din_0_valid   = v0;
        din_0         = d0;
        din_1_valid   = v1;
        din_1         = d1;
        mux_out_ready = rdy;
    endtask

    logic [7:0] seq_exp [4];

    initial begin
        seq_exp[0] = 8'h11; seq_exp[1] = 8'h22; seq_exp[2] = 8'h11; seq_exp[3] = 8'h22;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        // 1: reset for 2 cycles with both sources valid
        reset = 1'b1;
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_r0", din_0_ready, 1'b0);
            chk("rst_r1", din_1_ready, 1'b0);
            tick();
            chk("rst_valid", mux_out_valid, 1'b0);
            chk("rst_data", mux_out, 8'h00);
        end
`ifdef ARB_STATS_EN
        chk("rst_cnt0", gnt_cnt_0, 16'd0);
        chk("rst_cnt1", gnt_cnt_1, 16'd0);
`endif

        // 2: single source 0 with A5
        reset = 1'b0;
        drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
        settle();
        chk("single_r0", din_0_ready, 1'b1);
        chk("single_r1", din_1_ready, 1'b0);
        chk("single_sel", sel, 1'b0);
        tick();
        chk("single_data", mux_out, 8'hA5);
        chk("single_valid", mux_out_valid, 1'b1);

        // reset restores LAST_INIT before the alternation test
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // 3: both valid, consumer always ready -> 11,22,11,22
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("alt_sel", sel, i[0]);
            chk("alt_one_ready", {din_1_ready, din_0_ready}, i[0] ? 2'b10 : 2'b01);
            tick();
            chk("alt_data", mux_out, seq_exp[i]);
            chk("alt_valid", mux_out_valid, 1'b1);
        end

        // 4: stall 3 cycles while FULL holding 22
        mux_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_readys", {din_1_ready, din_0_ready}, 2'b00);
            tick();
            chk("stall_data", mux_out, 8'h22);
            chk("stall_valid", mux_out_valid, 1'b1);
        end
        mux_out_ready = 1'b1;
        settle();
        chk("unstall_r0", din_0_ready, 1'b1);
        chk("unstall_sel", sel, 1'b0);
        tick();
        chk("unstall_data", mux_out, 8'h11);
        chk("unstall_valid", mux_out_valid, 1'b1);

        // drain: no requesters, consumer ready -> valid clears, data kept
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        settle();
        chk("drain_sel", sel, 1'b0);
        chk("drain_readys", {din_1_ready, din_0_ready}, 2'b00);
        tick();
        chk("drain_valid", mux_out_valid, 1'b0);
        chk("drain_data", mux_out, 8'h11);

        // only source 1 requests while EMPTY, consumer not ready
        drive(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        settle();
        chk("only1_sel", sel, 1'b1);
        chk("only1_readys", {din_1_ready, din_0_ready}, 2'b10);
        tick();
        chk("only1_data", mux_out, 8'h77);

        // 5: load 3C, stall, then reset while FULL
        drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        tick();
        chk("pre_rst_data", mux_out, 8'h3C);
        drive(1'b1, 8'h44, 1'b1, 8'h55, 1'b0);
        reset = 1'b1;
        settle();
        chk("midrst_readys", {din_1_ready, din_0_ready}, 2'b00);
        tick();
        chk("midrst_valid", mux_out_valid, 1'b0);
        reset = 1'b0;
        mux_out_ready = 1'b1;
        settle();
        chk("post_rst_sel", sel, 1'b0);
        chk("post_rst_r0", din_0_ready, 1'b1);
        tick();
        chk("post_rst_data", mux_out, 8'h44);

`ifdef ARB_STATS_EN
        // 6: statistics counters
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 8'h00, 1'b1, 8'h02, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("cnt0_five", gnt_cnt_0, 16'd5);
        chk("cnt1_three", gnt_cnt_1, 16'd3);
        drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("clr_cnt0", gnt_cnt_0, 16'd0);
        chk("clr_cnt1", gnt_cnt_1, 16'd0);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        chk("cnt0_max", gnt_cnt_0, 16'hFFFF);
        tick();
        chk("cnt0_wrap", gnt_cnt_0, 16'd0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
